// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order word requests, buffers responses in a
// prefetch FIFO feeding decode, and squashes wrong-path words on a redirect.
module fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [31:0]   r_instr_mem [FIFO_DEPTH];
  logic [31:0]   r_pc_mem    [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic [CW:0]   w_credit_used;
  logic [31:0]   w_target;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  // Credits cover both buffered and in-flight words, so every response has a slot.
  assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, r_count};
  assign imem_req_valid = !reset && !PCSrcE && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_target       = PCTargetE & 32'hFFFF_FFFC;

  assign w_drop = imem_rsp_valid && (r_discard != {CW{1'b0}});
  assign w_push = !reset && !PCSrcE && imem_rsp_valid && (r_discard == {CW{1'b0}});
  assign w_pop  = fetch_valid && fetch_ready && !PCSrcE;

  // An empty FIFO shows a NOP at the PC of the next word expected back.
  assign fetch_valid = (r_count != {CW{1'b0}});
  assign InstrD      = fetch_valid ? r_instr_mem[r_rd_ptr] : NOP;
  assign PCD         = fetch_valid ? r_pc_mem[r_rd_ptr] : r_rsp_pc;
  assign PCPlus4D    = PCD + 32'd4;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_rsp_data;
      r_pc_mem[r_wr_ptr]    <= r_rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_rd_ptr      <= {AW{1'b0}};
      r_wr_ptr      <= {AW{1'b0}};
      r_count       <= {CW{1'b0}};
      r_outstanding <= {CW{1'b0}};
      r_discard     <= {CW{1'b0}};
    end else if (PCSrcE) begin
      // Everything still in flight is wrong-path, except a word landing right now.
      r_fetch_pc    <= w_target;
      r_rsp_pc      <= w_target;
      r_rd_ptr      <= {AW{1'b0}};
      r_wr_ptr      <= {AW{1'b0}};
      r_count       <= {CW{1'b0}};
      r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
      r_discard     <= r_outstanding - CW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_drop) begin
        r_discard <= r_discard - CW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the pipelined datapath's decode register. It owns the fetch PC and issues in-order word requests to the instruction memory. Responses land in a small prefetch FIFO that presents InstrD/PCD/PCPlus4D with a valid/ready handshake. On a taken branch/jump (PCSrcE) it redirects to PCTargetE, discards buffered and in-flight wrong-path words, and refetches.

## Interface
Parameters:
- FIFO_DEPTH, 4: prefetch entries; power of two, ≥2; also caps outstanding requests.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word address of request (bits [1:0] = 0).
- imem_rsp_valid  in  1  one response word this cycle; responses return in request order, latency ≥1.
- imem_rsp_data  in  32  instruction word.
- PCSrcE  in  1  redirect strobe from execute.
- PCTargetE  in  32  redirect target.
- fetch_valid  out  1  InstrD/PCD/PCPlus4D valid.
- fetch_ready  in  1  decode accepts (driven as !StallD).
- InstrD  out  32  FIFO head instruction; 32'h0000_0013 (NOP) when empty.
- PCD  out  32  PC of head instruction.
- PCPlus4D  out  32  PCD + 4, modulo 2^32.

## Operation
- State: fetch_pc (next request address), rsp_pc (PC of next kept response), FIFO of {instr, pc} with count, outstanding counter, discard counter. Counters are $clog2(FIFO_DEPTH)+1 bits wide.
- Issue: imem_req_valid = !reset && !PCSrcE && (outstanding + count < FIFO_DEPTH). This credit rule guarantees a FIFO slot for every response.
- Issue handshake: on req_valid && req_ready, fetch_pc += 4 and outstanding++. While ready is low, addr holds stable.
- Response handling: every imem_rsp_valid decrements outstanding.
  - If discard > 0 (or PCSrcE is high this cycle), the word is dropped and discard decrements.
  - Otherwise push {imem_rsp_data, rsp_pc} and rsp_pc += 4.
- Output: head drives InstrD/PCD. Pop on fetch_valid && fetch_ready. Push and pop may occur in the same cycle; count is unchanged.
- Redirect (PCSrcE=1, single cycle), which overrides all other updates that cycle:
  - FIFO cleared (count=0).
  - fetch_pc and rsp_pc are set to PCTargetE.
  - discard = outstanding − imem_rsp_valid.
  - outstanding = outstanding − imem_rsp_valid.
  - No request issued and no pop.
- Back-to-back redirects: each recomputes discard from current outstanding; the last target wins.
- Reset outputs: imem_req_valid=0, imem_req_addr=RESET_PC, fetch_valid=0, InstrD=32'h13, PCD=RESET_PC, PCPlus4D=RESET_PC+4. All counters are 0. The instruction memory is reset by the same reset and drops in-flight requests.
- Misaligned PCTargetE: bits [1:0] forced to 0.

## Timing
- Fetch PC to request: imem_req_valid is high in the first cycle after reset deasserts, with addr = RESET_PC.
- Response to output: a word accepted at edge N shows fetch_valid=1 after edge N. There is no same-cycle bypass from imem_rsp to InstrD.
- Best case throughput: 1 instruction/cycle with 1-cycle memory and fetch_ready=1.
- Redirect cycle R: first request to PCTargetE is issued in cycle R+1, provided credit is available.
- fetch_valid drops to 0 the cycle after R.
- imem_req_valid is combinational on PCSrcE and registered state only. All data outputs are registered (FIFO head).
- FIFO full (count=FIFO_DEPTH) implies outstanding=0, so no push is possible. Empty FIFO implies fetch_valid=0 and pop is ignored.

## Test plan
- Reset, 1-cycle memory returning addr-based words, fetch_ready=1 -> requests 0x0,0x4,0x8… on consecutive cycles. Outputs PCD=0x0,0x4,0x8 in order with matching InstrD, PCPlus4D=PCD+4, no gaps after the first valid.
- fetch_ready=0 for 10 cycles -> requests stop once outstanding+count=4. fetch_valid held with PCD stable. On release, all 4 words drain in order with no loss or duplication.
- 3-cycle memory latency with 2 requests outstanding, PCSrcE pulse with target 0x100 -> both late responses dropped. Next fetch_valid shows PCD=0x100, then 0x104.
- PCSrcE in the same cycle as imem_rsp_valid -> that word dropped. discard = outstanding−1. No wrong-path PC ever appears on PCD.
- imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1 and imem_req_addr is unchanged. fetch_pc advances only on the accepting cycle.
- Assert reset mid-stream with FIFO half full -> next cycle fetch_valid=0, InstrD=0x13, imem_req_addr=RESET_PC. Fetch restarts at RESET_PC after reset deasserts.
